pid_param_loader: RTL

// Downstream consumer of the frontpanel parameter wires for the PID cores. Host writes one shared

---
 rtl/pid_param_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pid_param_loader.sv
// pid_param_loader: snapshots one shared setpoint/P/I/D set and loads it into masked per-channel shadow banks, one channel per cycle
// Ports: clk_in/reset_in (sync, active-high); module_update_in load request; update_en_in channel mask;
//   setpoint_in/p_coef_in/i_coef_in/d_coef_in shared set; *_out banks (channel k at [k*W +: W]);
//   param_valid_out per-channel load pulse; busy_out scan active; overrun_out sticky request-while-busy;
//   clamp_out sticky coefficient saturation flag.
// Macro PID_PARAM_CLAMP_EN: saturate coefficients to +/-COEF_LIM at the snapshot; otherwise pass through and clamp_out stays 0.
module pid_param_loader #(
  parameter int N_CHAN   = 8,
  parameter int W_SP     = 16,
  parameter int W_COEF   = 16,
  parameter int COEF_LIM = 8191
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     module_update_in,
  input  logic [N_CHAN-1:0]        update_en_in,
  input  logic [W_SP-1:0]          setpoint_in,
  input  logic [W_COEF-1:0]        p_coef_in,
  input  logic [W_COEF-1:0]        i_coef_in,
  input  logic [W_COEF-1:0]        d_coef_in,
  output logic [N_CHAN*W_SP-1:0]   setpoint_out,
  output logic [N_CHAN*W_COEF-1:0] p_coef_out,
  output logic [N_CHAN*W_COEF-1:0] i_coef_out,
  output logic [N_CHAN*W_COEF-1:0] d_coef_out,
  output logic [N_CHAN-1:0]        param_valid_out,
  output logic                     busy_out,
  output logic                     overrun_out,
  output logic                     clamp_out
);
  localparam int CW = N_CHAN > 1 ? $clog2(N_CHAN) : 1;
  typedef enum logic {IDLE, SCAN} state_t;
  state_t              r_state;
  logic [CW-1:0]       r_ch;
  logic [N_CHAN-1:0]   r_mask;
  logic [W_SP-1:0]     r_stg_sp;
  logic [W_COEF-1:0]   r_stg_p, r_stg_i, r_stg_d;
  logic [W_SP-1:0]     r_sp [N_CHAN];
  logic [W_COEF-1:0]   r_p  [N_CHAN];
  logic [W_COEF-1:0]   r_i  [N_CHAN];
  logic [W_COEF-1:0]   r_d  [N_CHAN];
  logic [N_CHAN-1:0]   r_valid;
  logic                r_busy, r_ovr, r_clamp;
  logic [W_COEF-1:0]   w_p, w_i, w_d;
  logic                w_clip;
`ifdef PID_PARAM_CLAMP_EN
  localparam logic signed [W_COEF-1:0] LIM = W_COEF'(COEF_LIM);
  function automatic logic [W_COEF-1:0] sat(input logic signed [W_COEF-1:0] v);
    return v > LIM ? LIM : (v < -LIM ? -LIM : v);
  endfunction
  assign w_p    = sat(p_coef_in);
  assign w_i    = sat(i_coef_in);
  assign w_d    = sat(d_coef_in);
  assign w_clip = (w_p != p_coef_in) | (w_i != i_coef_in) | (w_d != d_coef_in);
`else
  logic w_unused_lim;
  assign w_unused_lim = ^32'(COEF_LIM);
  assign w_p    = p_coef_in;
  assign w_i    = i_coef_in;
  assign w_d    = d_coef_in;
  assign w_clip = 1'b0;
`endif
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state  <= IDLE;
      r_ch     <= '0;
      r_mask   <= '0;
      r_stg_sp <= '0;
      r_stg_p  <= '0;
      r_stg_i  <= '0;
      r_stg_d  <= '0;
      r_valid  <= '0;
      r_busy   <= 1'b0;
      r_ovr    <= 1'b0;
      r_clamp  <= 1'b0;
      for (int k = 0; k < N_CHAN; k++) begin
        r_sp[k] <= '0;
        r_p[k]  <= '0;
        r_i[k]  <= '0;
        r_d[k]  <= '0;
      end
    end else begin
      r_valid <= '0;
      if (r_state == IDLE) begin
        if (module_update_in) begin
          r_mask   <= update_en_in;
          r_stg_sp <= setpoint_in;
          r_stg_p  <= w_p;
          r_stg_i  <= w_i;
          r_stg_d  <= w_d;
          r_clamp  <= r_clamp | w_clip;
          r_ch     <= '0;
          r_busy   <= 1'b1;
          r_state  <= SCAN;
        end
      end else begin
        if (module_update_in) r_ovr <= 1'b1;
        if (r_mask[r_ch]) begin
          r_sp[r_ch]    <= r_stg_sp;
          r_p[r_ch]     <= r_stg_p;
          r_i[r_ch]     <= r_stg_i;
          r_d[r_ch]     <= r_stg_d;
          r_valid[r_ch] <= 1'b1;
        end
        if (r_ch == CW'(N_CHAN - 1)) begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        r_ch <= r_ch + 1'b1;
      end
    end
  end
  for (genvar k = 0; k < N_CHAN; k++) begin : g_bank
    assign setpoint_out[k*W_SP +: W_SP] = r_sp[k];
    assign p_coef_out[k*W_COEF +: W_COEF] = r_p[k];
    assign i_coef_out[k*W_COEF +: W_COEF] = r_i[k];
    assign d_coef_out[k*W_COEF +: W_COEF] = r_d[k];
  end
  assign param_valid_out = r_valid;
  assign busy_out        = r_busy;
  assign overrun_out     = r_ovr;
  assign clamp_out       = r_clamp;
endmodule
